// File: rtl/ascii_cmd_parser.sv
// ascii_cmd_parser: streaming ASCII command decoder between uart_rx and the
// chess game controller. WASD keys produce immediate direction pulses, while
// digits are assembled into a fixed-length numeric command released on Enter.
// Optional feature macro: ASCII_CMD_LOWERCASE_EN (lowercase w/a/s/d accepted).
module ascii_cmd_parser #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [7:0]                             rx_data,
  input  logic                                   rx_valid,
  output logic                                   dir_valid,
  output logic [2:0]                             dir_code,
  output logic                                   cmd_valid,
  output logic [NUM_DIGITS*DIGIT_W-1:0]          cmd_data,
  output logic                                   cmd_err,
  output logic [$clog2(NUM_DIGITS+1)-1:0]        digit_count
);

  localparam int BUF_W = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_DIGITS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  // OVER means a digit arrived while the buffer was already full; the
  // buffer itself still holds the NUM_DIGITS digits typed before it.
  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FULL,
    OVER
  } state_t;

  state_t                 state_q;
  logic [BUF_W-1:0]       buf_q;
  logic [CNT_W-1:0]       count_q;
  logic                   dirValid_q;
  logic [2:0]             dirCode_q;
  logic                   cmdValid_q;
  logic                   cmdErr_q;
  logic [BUF_W-1:0]       cmdData_q;

  logic                   isDigit;
  logic [DIGIT_W-1:0]     digitVal;
  logic [2:0]             dirKey;
  logic [BUF_W+DIGIT_W-1:0] bufExt;
  logic [BUF_W-1:0]       bufPush;
  logic [BUF_W-1:0]       bufPop;
  logic [CNT_W-1:0]       countInc;
  logic [CNT_W-1:0]       countDec;

  // Digit recognition and the two buffer edits (append newest digit at the
  // LSB end so the first typed digit ends up in the MSBs, or drop the newest).
  always_comb begin
    isDigit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    digitVal = DIGIT_W'(rx_data[3:0]);
    bufExt   = {buf_q, digitVal};
    bufPush  = bufExt[BUF_W-1:0];
    bufPop   = buf_q >> DIGIT_W;
    countInc = count_q + ONE_CNT;
    countDec = count_q - ONE_CNT;
  end

  // Map the incoming byte to a cursor direction code, zero if not a WASD key.
  always_comb begin
    dirKey = 3'd0;
    case (rx_data)
      8'h57:   dirKey = 3'd1;
      8'h41:   dirKey = 3'd2;
      8'h53:   dirKey = 3'd3;
      8'h44:   dirKey = 3'd4;
`ifdef ASCII_CMD_LOWERCASE_EN
      8'h77:   dirKey = 3'd1;
      8'h61:   dirKey = 3'd2;
      8'h73:   dirKey = 3'd3;
      8'h64:   dirKey = 3'd4;
`endif
      default: dirKey = 3'd0;
    endcase
  end

  // Parser state, digit buffer and all registered outputs; pulses default low
  // every cycle so each event produces exactly one cycle of output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      count_q    <= '0;
      dirValid_q <= 1'b0;
      dirCode_q  <= 3'd0;
      cmdValid_q <= 1'b0;
      cmdErr_q   <= 1'b0;
      cmdData_q  <= '0;
    end else begin
      dirValid_q <= 1'b0;
      dirCode_q  <= 3'd0;
      cmdValid_q <= 1'b0;
      cmdErr_q   <= 1'b0;
      if (rx_valid) begin
        if (isDigit) begin
          if ((state_q != OVER) && (count_q != MAX_CNT)) begin
            buf_q   <= bufPush;
            count_q <= countInc;
            state_q <= (countInc == MAX_CNT) ? FULL : COLLECT;
          end else begin
            state_q <= OVER;
          end
        end else if (dirKey != 3'd0) begin
          dirValid_q <= 1'b1;
          dirCode_q  <= dirKey;
        end else begin
          case (rx_data)
            8'h08: begin
              if (state_q == OVER) begin
                state_q <= FULL;
              end else if (count_q != '0) begin
                buf_q   <= bufPop;
                count_q <= countDec;
                state_q <= (count_q == ONE_CNT) ? IDLE : COLLECT;
              end
            end
            8'h0D: begin
              if (state_q == FULL) begin
                cmdValid_q <= 1'b1;
                cmdData_q  <= buf_q;
              end else begin
                cmdErr_q <= 1'b1;
              end
              buf_q   <= '0;
              count_q <= '0;
              state_q <= IDLE;
            end
            8'h1B: begin
              buf_q   <= '0;
              count_q <= '0;
              state_q <= IDLE;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    dir_valid   = dirValid_q;
    dir_code    = dirCode_q;
    cmd_valid   = cmdValid_q;
    cmd_err     = cmdErr_q;
    cmd_data    = cmdData_q;
    digit_count = count_q;
  end

endmodule

// File: tb/tb_ascii_cmd_parser.sv
// tb_ascii_cmd_parser: table-driven bench for ascii_cmd_parser. Each record is
// one cycle of stimulus plus the outputs expected on the following cycle;
// expectations ride a scoreboard queue from drive time to sample time.
module tb_ascii_cmd_parser;

  typedef struct {
    logic        rst;
    logic        rxValid;
    logic [7:0]  rxData;
    logic        dirValid;
    logic [2:0]  dirCode;
    logic        cmdValid;
    logic        cmdErr;
    logic [15:0] cmdData;
    logic [2:0]  count;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        dir_valid;
  logic [2:0]  dir_code;
  logic        cmd_valid;
  logic [15:0] cmd_data;
  logic        cmd_err;
  logic [2:0]  digit_count;

  vec_t vecs[$];
  vec_t sb[$];
  int   checkCount;
  int   passCount;
  int   vecIdx;

  ascii_cmd_parser #(.NUM_DIGITS(4), .DIGIT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .dir_valid   (dir_valid),
    .dir_code    (dir_code),
    .cmd_valid   (cmd_valid),
    .cmd_data    (cmd_data),
    .cmd_err     (cmd_err),
    .digit_count (digit_count)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mkVec(input logic r, input logic v, input logic [7:0] d,
                                 input logic dv, input logic [2:0] dc, input logic cv,
                                 input logic ce, input logic [15:0] data, input logic [2:0] cnt);
    vec_t t;
    t.rst = r; t.rxValid = v; t.rxData = d;
    t.dirValid = dv; t.dirCode = dc; t.cmdValid = cv; t.cmdErr = ce;
    t.cmdData = data; t.count = cnt;
    return t;
  endfunction

  // Plain byte that produces no pulse.
  task automatic addQuiet(input logic [7:0] d, input logic [15:0] data, input logic [2:0] cnt);
    vecs.push_back(mkVec(1'b0, 1'b1, d, 1'b0, 3'd0, 1'b0, 1'b0, data, cnt));
  endtask

  task automatic addDir(input logic [7:0] d, input logic [2:0] dc, input logic [15:0] data, input logic [2:0] cnt);
    vecs.push_back(mkVec(1'b0, 1'b1, d, 1'b1, dc, 1'b0, 1'b0, data, cnt));
  endtask

  task automatic addEnter(input logic ok, input logic [15:0] data);
    vecs.push_back(mkVec(1'b0, 1'b1, 8'h0D, 1'b0, 3'd0, ok, ~ok, data, 3'd0));
  endtask

  task automatic applyStimulus(input vec_t v);
    rst      = v.rst;
    rx_valid = v.rxValid;
    rx_data  = v.rxData;
    sb.push_back(v);
  endtask

  task automatic checkField(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    if (sb.size() == 0) begin
      checkCount++;
      $display("[TB] FAIL scoreboard step %0d: got empty queue expected entry", idx);
    end else begin
      e = sb.pop_front();
      checkField("dir_valid",   idx, {15'd0, dir_valid},   {15'd0, e.dirValid});
      checkField("dir_code",    idx, {13'd0, dir_code},    {13'd0, e.dirCode});
      checkField("cmd_valid",   idx, {15'd0, cmd_valid},   {15'd0, e.cmdValid});
      checkField("cmd_err",     idx, {15'd0, cmd_err},     {15'd0, e.cmdErr});
      checkField("cmd_data",    idx, cmd_data,             e.cmdData);
      checkField("digit_count", idx, {13'd0, digit_count}, {13'd0, e.count});
    end
  endtask

  task automatic runCycle(input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput(vecIdx);
    vecIdx++;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    vecIdx     = 0;
    rst        = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;

    // Reset state
    vecs.push_back(mkVec(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000, 3'd0));
    // "1234" Enter
    addQuiet("1", 16'h0000, 3'd1);
    addQuiet("2", 16'h0000, 3'd2);
    addQuiet("3", 16'h0000, 3'd3);
    addQuiet("4", 16'h0000, 3'd4);
    addEnter(1'b1, 16'h1234);
    // "78" Enter -> error, data held
    addQuiet("7", 16'h1234, 3'd1);
    addQuiet("8", 16'h1234, 3'd2);
    addEnter(1'b0, 16'h1234);
    // "12345" BS Enter -> overflow cleared, command intact
    addQuiet("1", 16'h1234, 3'd1);
    addQuiet("2", 16'h1234, 3'd2);
    addQuiet("3", 16'h1234, 3'd3);
    addQuiet("4", 16'h1234, 3'd4);
    addQuiet("5", 16'h1234, 3'd4);
    addQuiet(8'h08, 16'h1234, 3'd4);
    addEnter(1'b1, 16'h1234);
    // "96" BS "501" Enter
    addQuiet("9", 16'h1234, 3'd1);
    addQuiet("6", 16'h1234, 3'd2);
    addQuiet(8'h08, 16'h1234, 3'd1);
    addQuiet("5", 16'h1234, 3'd2);
    addQuiet("0", 16'h1234, 3'd3);
    addQuiet("1", 16'h1234, 3'd4);
    addEnter(1'b1, 16'h9501);
    // Back-to-back direction keys, unmapped byte, lowercase w
    addDir("W", 3'd1, 16'h9501, 3'd0);
    addDir("D", 3'd4, 16'h9501, 3'd0);
    addQuiet("x", 16'h9501, 3'd0);
    addDir("S", 3'd3, 16'h9501, 3'd0);
`ifdef ASCII_CMD_LOWERCASE_EN
    addDir(8'h77, 3'd1, 16'h9501, 3'd0);
`else
    addQuiet(8'h77, 16'h9501, 3'd0);
`endif
    // Direction key mid-command leaves buffer alone
    addQuiet("1", 16'h9501, 3'd1);
    addDir("A", 3'd2, 16'h9501, 3'd1);
    addQuiet("2", 16'h9501, 3'd2);
    addQuiet("3", 16'h9501, 3'd3);
    addQuiet("4", 16'h9501, 3'd4);
    addEnter(1'b1, 16'h1234);
    // Backspace on empty buffer is a no-op
    addQuiet(8'h08, 16'h1234, 3'd0);
    // "22" Esc Enter -> error
    addQuiet("2", 16'h1234, 3'd1);
    addQuiet("2", 16'h1234, 3'd2);
    addQuiet(8'h1B, 16'h1234, 3'd0);
    addEnter(1'b0, 16'h1234);
    // Bytes without rx_valid are ignored
    vecs.push_back(mkVec(1'b0, 1'b0, "3", 1'b0, 3'd0, 1'b0, 1'b0, 16'h1234, 3'd0));
    vecs.push_back(mkVec(1'b0, 1'b0, 8'h0D, 1'b0, 3'd0, 1'b0, 1'b0, 16'h1234, 3'd0));
    // Overflow then Enter -> error
    addQuiet("5", 16'h1234, 3'd1);
    addQuiet("6", 16'h1234, 3'd2);
    addQuiet("7", 16'h1234, 3'd3);
    addQuiet("8", 16'h1234, 3'd4);
    addQuiet("9", 16'h1234, 3'd4);
    addEnter(1'b0, 16'h1234);
    // Overflow, BS, another digit overflows again -> error
    addQuiet("1", 16'h1234, 3'd1);
    addQuiet("2", 16'h1234, 3'd2);
    addQuiet("3", 16'h1234, 3'd3);
    addQuiet("4", 16'h1234, 3'd4);
    addQuiet("5", 16'h1234, 3'd4);
    addQuiet("6", 16'h1234, 3'd4);
    addQuiet(8'h08, 16'h1234, 3'd4);
    addQuiet("7", 16'h1234, 3'd4);
    addEnter(1'b0, 16'h1234);

    foreach (vecs[i]) runCycle(vecs[i]);

    // Reset mid-command, with an Enter strobe landing on the reset cycle
    runCycle(mkVec(1'b0, 1'b1, "4", 1'b0, 3'd0, 1'b0, 1'b0, 16'h1234, 3'd1));
    runCycle(mkVec(1'b0, 1'b1, "5", 1'b0, 3'd0, 1'b0, 1'b0, 16'h1234, 3'd2));
    runCycle(mkVec(1'b1, 1'b1, 8'h0D, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000, 3'd0));
    runCycle(mkVec(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000, 3'd0));
    runCycle(mkVec(1'b0, 1'b1, "1", 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000, 3'd1));
    runCycle(mkVec(1'b0, 1'b1, "1", 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000, 3'd2));
    runCycle(mkVec(1'b0, 1'b1, "1", 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000, 3'd3));
    runCycle(mkVec(1'b0, 1'b1, "1", 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000, 3'd4));
    runCycle(mkVec(1'b0, 1'b1, 8'h0D, 1'b0, 3'd0, 1'b1, 1'b0, 16'h1111, 3'd0));
    // Idle cycle after the command: pulse gone, data held
    runCycle(mkVec(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 16'h1111, 3'd0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
